// File: rtl/pm_switch_sequencer_if.sv
// Handshake bundle between the power-switch sequencer and its controller/environment.
// Slave modport is the sequencer view; master modport is the controller view.
interface pm_switch_sequencer_if;
  logic pwr_req;
  logic sw_ack;
  logic err_clr;
  logic sw_en;
  logic iso_en;
  logic mux_sel;
  logic save;
  logic restore;
  logic pwr_ack;
  logic busy;
  logic timeout_err;

  modport master (
    output pwr_req, sw_ack, err_clr,
    input  sw_en, iso_en, mux_sel, save, restore, pwr_ack, busy, timeout_err
  );

  modport slave (
    input  pwr_req, sw_ack, err_clr,
    output sw_en, iso_en, mux_sel, save, restore, pwr_ack, busy, timeout_err
  );
endinterface

// File: rtl/pm_switch_sequencer.sv
// Power-domain switch sequencer: isolate, save, switch off; switch on, restore, de-isolate.
// Every output is a flop decoded from the next state, so nothing reaches the outputs combinationally.
module pm_switch_sequencer #(
  parameter int unsigned ISO_DLY = 2,
  parameter int unsigned SW_TMO  = 200
) (
  input logic clk,
  input logic rst,
  pm_switch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ON, ST_ISO, ST_SAVE, ST_SWOFF, ST_OFF, ST_SWON, ST_RESTORE, ST_DEISO
  } stateT;

  localparam logic [7:0] ISO_LOAD = 8'(ISO_DLY - 1);
  localparam logic [7:0] SW_LOAD  = 8'(SW_TMO - 1);

  stateT      state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ackMeta_q, ackSync_q;
  logic       swEn_q, swEn_d;
  logic       isoEn_q, isoEn_d;
  logic       muxSel_q, muxSel_d;
  logic       save_q, save_d;
  logic       restore_q, restore_d;
  logic       pwrAck_q, pwrAck_d;
  logic       busy_q, busy_d;
  logic       timeoutErr_q, timeoutErr_d;
  logic       timeoutHit;

  // sw_ack comes from the switch chain in another timing domain; idle level is "supplied".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ackMeta_q <= 1'b1;
      ackSync_q <= 1'b1;
    end else begin
      ackMeta_q <= bus.sw_ack;
      ackSync_q <= ackMeta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ON;
      cnt_q        <= 8'd0;
      swEn_q       <= 1'b1;
      isoEn_q      <= 1'b0;
      muxSel_q     <= 1'b0;
      save_q       <= 1'b0;
      restore_q    <= 1'b0;
      pwrAck_q     <= 1'b1;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      swEn_q       <= swEn_d;
      isoEn_q      <= isoEn_d;
      muxSel_q     <= muxSel_d;
      save_q       <= save_d;
      restore_q    <= restore_d;
      pwrAck_q     <= pwrAck_d;
      busy_q       <= busy_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeoutHit = 1'b0;
    case (state_q)
      ST_ON: begin
        if (!bus.pwr_req) begin
          state_d = ST_ISO;
          cnt_d   = ISO_LOAD;
        end
      end
      ST_ISO: begin
        if (cnt_q == 8'd0) state_d = ST_SAVE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_SAVE: begin
        state_d = ST_SWOFF;
        cnt_d   = SW_LOAD;
      end
      // A real acknowledge takes priority over an expiring counter.
      ST_SWOFF: begin
        if (!ackSync_q) begin
          state_d = ST_OFF;
        end else if (cnt_q == 8'd0) begin
          state_d    = ST_OFF;
          timeoutHit = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_OFF: begin
        if (bus.pwr_req) begin
          state_d = ST_SWON;
          cnt_d   = SW_LOAD;
        end
      end
      ST_SWON: begin
        if (ackSync_q) begin
          state_d = ST_RESTORE;
        end else if (cnt_q == 8'd0) begin
          state_d    = ST_RESTORE;
          timeoutHit = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESTORE: begin
        state_d = ST_DEISO;
        cnt_d   = ISO_LOAD;
      end
      ST_DEISO: begin
        if (cnt_q == 8'd0) state_d = ST_ON;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_ON;
    endcase

    // Outputs decode the state being entered so they change in step with the state register.
    swEn_d    = !((state_d == ST_SWOFF) || (state_d == ST_OFF));
    isoEn_d   = (state_d != ST_ON);
    muxSel_d  = (state_d != ST_ON);
    save_d    = (state_d == ST_SAVE);
    restore_d = (state_d == ST_RESTORE);
    busy_d    = !((state_d == ST_ON) || (state_d == ST_OFF));

    pwrAck_d = pwrAck_q;
    if (state_d == ST_ON)  pwrAck_d = 1'b1;
    if (state_d == ST_OFF) pwrAck_d = 1'b0;

    timeoutErr_d = timeoutErr_q;
    if (bus.err_clr) timeoutErr_d = 1'b0;
    if (timeoutHit)  timeoutErr_d = 1'b1;
  end

  assign bus.sw_en       = swEn_q;
  assign bus.iso_en      = isoEn_q;
  assign bus.mux_sel     = muxSel_q;
  assign bus.save        = save_q;
  assign bus.restore     = restore_q;
  assign bus.pwr_ack     = pwrAck_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeoutErr_q;

endmodule
